// File: rtl/usr_burst.sv
// Universal shift register with a counted-burst shift engine.
// Define USR_ROTATE_EN to enable the rotate modes (100/101); otherwise they behave as hold.
module usr_burst #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [2:0]       i_mode,
  input  logic [WIDTH-1:0] i_pin,
  input  logic             i_lin,
  input  logic             i_rin,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_count,
  output logic [WIDTH-1:0] o_out,
  output logic             o_lout,
  output logic             o_rout,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHR  = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_ROL  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_out;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_mode;
  logic             r_busy;
  logic             r_done;

  logic [0:0]       w_state_nxt;
  logic [WIDTH-1:0] w_out_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       w_mode_nxt;
  logic             w_done_nxt;
  logic [2:0]       w_op_mode;
  logic [WIDTH-1:0] w_res;
  logic             w_shift_class;

  // A burst replays its latched mode; in IDLE the live mode is applied.
  assign w_op_mode = (r_state == ST_SHIFT) ? r_mode : i_mode;

  // Single-step result of the selected operation on the current register.
  always_comb begin
    w_res = r_out;
    case (w_op_mode)
      M_HOLD: w_res = r_out;
      M_SHR:  w_res = {i_rin, r_out[WIDTH-1:1]};
      M_SHL:  w_res = {r_out[WIDTH-2:0], i_lin};
      M_LOAD: w_res = i_pin;
`ifdef USR_ROTATE_EN
      M_ROR:  w_res = {r_out[0], r_out[WIDTH-1:1]};
      M_ROL:  w_res = {r_out[WIDTH-2:0], r_out[WIDTH-1]};
`endif
      M_ASR:  w_res = {r_out[WIDTH-1], r_out[WIDTH-1:1]};
      M_CLR:  w_res = '0;
      default: w_res = r_out;
    endcase
  end

  // Modes eligible to be repeated as a burst.
  always_comb begin
    w_shift_class = 1'b0;
    case (i_mode)
      M_SHR, M_SHL, M_ASR: w_shift_class = 1'b1;
`ifdef USR_ROTATE_EN
      M_ROR, M_ROL:        w_shift_class = 1'b1;
`endif
      default:             w_shift_class = 1'b0;
    endcase
  end

  // Next-state and datapath control; done is a pulse and self-clears every edge.
  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = r_out;
    w_cnt_nxt   = r_cnt;
    w_mode_nxt  = r_mode;
    w_done_nxt  = 1'b0;
    if (i_en) begin
      case (r_state)
        ST_IDLE: begin
          if (i_start && w_shift_class) begin
            w_mode_nxt = i_mode;
            w_cnt_nxt  = i_count;
            if (i_count == '0) begin
              w_done_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_SHIFT;
            end
          end else begin
            w_out_nxt = w_res;
          end
        end
        ST_SHIFT: begin
          w_out_nxt = w_res;
          w_cnt_nxt = r_cnt - CNT_W'(1);
          if (r_cnt <= CNT_W'(1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_out   <= '0;
      r_cnt   <= '0;
      r_mode  <= M_HOLD;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mode  <= w_mode_nxt;
      r_busy  <= (w_state_nxt == ST_SHIFT);
      r_done  <= w_done_nxt;
    end
  end

  assign o_out  = r_out;
  assign o_lout = r_out[WIDTH-1];
  assign o_rout = r_out[0];
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule
